pong_engine: RTL and testbench

- Parametrised successor to the single-speed pong state machine: owns ball, both paddles and both scores for a rectangular playfield of configurable size.
- Advances the game once per frame tick; adds serve delay, paddle clamping, configurable speeds, saturating scores and a win condition.
- Sits between the debounced button inputs and the VGA renderer / score display.

---
 rtl/pong_pkg.sv | 22 ++
 rtl/pong_if.sv | 37 +++
 rtl/pong_paddle.sv | 51 +++++
 rtl/pong_engine.sv | 228 ++++++++++++++++++++++
 tb/tb_pong_engine.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/pong_pkg.sv
// Shared game types: FSM state encoding, direction and player codes.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pong_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SERVE = 3'd1,
    PLAY  = 3'd2,
    SCORE = 3'd3,
    OVER  = 3'd4
  } state_t;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;
  localparam logic DIR_UP    = 1'b0;
  localparam logic DIR_DOWN  = 1'b1;

  localparam logic PLAYER_1 = 1'b0;
  localparam logic PLAYER_2 = 1'b1;

endpackage

// File: rtl/pong_if.sv
// Game bus: button/tick controls in, ball/paddle/score state out.
// Latency: n/a (wiring only).
// Backpressure: none; controls are sampled every cycle.
interface pong_if #(
  parameter int COORD_W = 10,
  parameter int SCORE_W = 4
);
  logic               tick;
  logic               start;
  logic               p1_up;
  logic               p1_dn;
  logic               p2_up;
  logic               p2_dn;
  logic [COORD_W-1:0] ball_x;
  logic [COORD_W-1:0] ball_y;
  logic [COORD_W-1:0] p1_y;
  logic [COORD_W-1:0] p2_y;
  logic [SCORE_W-1:0] score_1;
  logic [SCORE_W-1:0] score_2;
  logic               point_1;
  logic               point_2;
  logic               game_over;
  logic               winner;
  logic [2:0]         state_out;

  modport master (
    output tick, start, p1_up, p1_dn, p2_up, p2_dn,
    input  ball_x, ball_y, p1_y, p2_y, score_1, score_2,
           point_1, point_2, game_over, winner, state_out
  );

  modport slave (
    input  tick, start, p1_up, p1_dn, p2_up, p2_dn,
    output ball_x, ball_y, p1_y, p2_y, score_1, score_2,
           point_1, point_2, game_over, winner, state_out
  );
endinterface

// File: rtl/pong_paddle.sv
// Paddle: vertical centre moved by up/down buttons, clamped to the field.
// Latency: y changes one cycle after an enabled tick.
// Backpressure: none; moves only on ticks while enabled.
module pong_paddle #(
  parameter int COORD_W      = 10,
  parameter int FIELD_H      = 480,
  parameter int PADDLE_HALF  = 32,
  parameter int PADDLE_SPEED = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
  input  logic               enable,
  input  logic               up,
  input  logic               dn,
  output logic [COORD_W-1:0] y
);
  // Two guard bits so a step past either edge stays representable before clamping.
  localparam int SW = COORD_W + 2;
  localparam logic signed [SW-1:0] Y_MIN = SW'(PADDLE_HALF);
  localparam logic signed [SW-1:0] Y_MAX = SW'(FIELD_H - 1 - PADDLE_HALF);
  localparam logic signed [SW-1:0] STEP  = SW'(PADDLE_SPEED);

  logic signed [SW-1:0] raw;
  logic [COORD_W-1:0]   y_nx;

  // Step in the pressed direction (both pressed cancels), then clamp.
  always_comb begin
    raw = $signed({2'b00, y});
    if (up && !dn) begin
      raw = raw - STEP;
    end else if (dn && !up) begin
      raw = raw + STEP;
    end
    if (raw < Y_MIN) begin
      raw = Y_MIN;
    end else if (raw > Y_MAX) begin
      raw = Y_MAX;
    end
    y_nx = raw[COORD_W-1:0];
  end

  // Position register: centred on reset, updated on enabled ticks.
  always_ff @(posedge clk) begin
    if (!rst) begin
      y <= COORD_W'(FIELD_H / 2);
    end else if (tick && enable) begin
      y <= y_nx;
    end
  end
endmodule

// File: rtl/pong_engine.sv
// Pong game engine: serve delay, ball flight, paddle hits, scoring, win detect.
// Latency: all outputs registered; a tick's effect is visible the next cycle.
// Backpressure: none; game advances only on frame ticks, start ignored mid-game.
module pong_engine #(
  parameter int COORD_W      = 10,
  parameter int FIELD_W      = 640,
  parameter int FIELD_H      = 480,
  parameter int PADDLE_HALF  = 32,
  parameter int PADDLE_X1    = 16,
  parameter int PADDLE_X2    = 623,
  parameter int BALL_R       = 4,
  parameter int BALL_SPEED   = 2,
  parameter int PADDLE_SPEED = 4,
  parameter int SCORE_W      = 4,
  parameter int WIN_SCORE    = 7,
  parameter int SERVE_TICKS  = 60
) (
  input logic   clk,
  input logic   rst,
  pong_if.slave bus
);
  import pong_pkg::*;

  if (!(PADDLE_X1 < PADDLE_X2 && PADDLE_X2 < FIELD_W)) begin : g_bad_paddle_x
    $error("pong_engine: paddle x positions out of order");
  end
  if (!(2 * PADDLE_HALF < FIELD_H)) begin : g_bad_paddle_h
    $error("pong_engine: paddle taller than field");
  end
  if (!(BALL_SPEED <= BALL_R)) begin : g_bad_speed
    $error("pong_engine: ball speed exceeds radius");
  end
  if (!(WIN_SCORE <= (1 << SCORE_W) - 1)) begin : g_bad_win
    $error("pong_engine: win score not reachable");
  end

  localparam int SW    = COORD_W + 2;
  localparam int CNT_W = $clog2(SERVE_TICKS + 1);
  localparam logic [COORD_W-1:0]   CX      = COORD_W'(FIELD_W / 2);
  localparam logic [COORD_W-1:0]   CY      = COORD_W'(FIELD_H / 2);
  localparam logic signed [SW-1:0] SPD     = SW'(BALL_SPEED);
  localparam logic signed [SW-1:0] Y_TOP   = SW'(BALL_R);
  localparam logic signed [SW-1:0] Y_BOT   = SW'(FIELD_H - 1 - BALL_R);
  localparam logic signed [SW-1:0] X_LEFT  = SW'(PADDLE_X1 + BALL_R);
  localparam logic signed [SW-1:0] X_RIGHT = SW'(PADDLE_X2 - BALL_R);
  localparam logic signed [SW-1:0] REACH   = SW'(PADDLE_HALF + BALL_R);
  localparam logic [CNT_W-1:0]     CNT_END = CNT_W'(SERVE_TICKS - 1);
  localparam logic [SCORE_W-1:0]   WIN     = SCORE_W'(WIN_SCORE);

  state_t               state, state_nx;
  logic [COORD_W-1:0]   ball_x, ball_y, bx_nx, by_nx, p1_y, p2_y;
  logic                 dir_x, dir_y, dir_x_nx, dir_y_nx;
  logic [CNT_W-1:0]     serve_cnt, cnt_nx;
  logic [SCORE_W-1:0]   score_1, score_2, s1_nx, s2_nx, inc_1, inc_2;
  logic                 point_1, point_2, pt1_nx, pt2_nx;
  logic                 winner, win_nx, scorer, scorer_nx;
  logic                 paddle_en;
  logic signed [SW-1:0] nx, ny, d1, d2;
  logic                 hit_1, hit_2;

  assign paddle_en = (state == SERVE) || (state == PLAY);

  pong_paddle #(.COORD_W(COORD_W), .FIELD_H(FIELD_H), .PADDLE_HALF(PADDLE_HALF),
                .PADDLE_SPEED(PADDLE_SPEED)) u_paddle_1 (
    .clk(clk), .rst(rst), .tick(bus.tick), .enable(paddle_en),
    .up(bus.p1_up), .dn(bus.p1_dn), .y(p1_y)
  );

  pong_paddle #(.COORD_W(COORD_W), .FIELD_H(FIELD_H), .PADDLE_HALF(PADDLE_HALF),
                .PADDLE_SPEED(PADDLE_SPEED)) u_paddle_2 (
    .clk(clk), .rst(rst), .tick(bus.tick), .enable(paddle_en),
    .up(bus.p2_up), .dn(bus.p2_dn), .y(p2_y)
  );

  // Candidate ball step and paddle reach, all from pre-tick positions.
  always_comb begin
    nx = (dir_x == DIR_RIGHT) ? $signed({2'b00, ball_x}) + SPD : $signed({2'b00, ball_x}) - SPD;
    ny = (dir_y == DIR_DOWN)  ? $signed({2'b00, ball_y}) + SPD : $signed({2'b00, ball_y}) - SPD;
    d1 = $signed({2'b00, ball_y}) - $signed({2'b00, p1_y});
    d2 = $signed({2'b00, ball_y}) - $signed({2'b00, p2_y});
    hit_1 = ((d1 < 0) ? -d1 : d1) <= REACH;
    hit_2 = ((d2 < 0) ? -d2 : d2) <= REACH;
  end

  assign inc_1 = (score_1 == '1) ? score_1 : score_1 + 1'b1;
  assign inc_2 = (score_2 == '1) ? score_2 : score_2 + 1'b1;

  // Next-state and datapath decisions for every game phase.
  always_comb begin
    state_nx  = state;
    bx_nx     = ball_x;
    by_nx     = ball_y;
    dir_x_nx  = dir_x;
    dir_y_nx  = dir_y;
    cnt_nx    = serve_cnt;
    s1_nx     = score_1;
    s2_nx     = score_2;
    pt1_nx    = 1'b0;
    pt2_nx    = 1'b0;
    win_nx    = winner;
    scorer_nx = scorer;
    case (state)
      IDLE, OVER: begin
        if (bus.start) begin
          state_nx = SERVE;
          s1_nx    = '0;
          s2_nx    = '0;
          win_nx   = 1'b0;
          dir_x_nx = DIR_RIGHT;
          cnt_nx   = '0;
          bx_nx    = CX;
          by_nx    = CY;
        end
      end
      SERVE: begin
        bx_nx = CX;
        by_nx = CY;
        if (bus.tick) begin
          if (serve_cnt == CNT_END) begin
            state_nx = PLAY;
            cnt_nx   = '0;
            dir_y_nx = ~dir_y;
          end else begin
            cnt_nx = serve_cnt + 1'b1;
          end
        end
      end
      PLAY: begin
        if (bus.tick) begin
          bx_nx = nx[COORD_W-1:0];
          by_nx = ny[COORD_W-1:0];
          if (ny <= Y_TOP) begin
            by_nx    = COORD_W'(BALL_R);
            dir_y_nx = DIR_DOWN;
          end else if (ny >= Y_BOT) begin
            by_nx    = COORD_W'(FIELD_H - 1 - BALL_R);
            dir_y_nx = DIR_UP;
          end
          if (dir_x == DIR_LEFT && nx <= X_LEFT) begin
            if (hit_1) begin
              bx_nx    = COORD_W'(PADDLE_X1 + BALL_R);
              dir_x_nx = DIR_RIGHT;
            end else begin
              state_nx  = SCORE;
              scorer_nx = PLAYER_2;
            end
          end else if (dir_x == DIR_RIGHT && nx >= X_RIGHT) begin
            if (hit_2) begin
              bx_nx    = COORD_W'(PADDLE_X2 - BALL_R);
              dir_x_nx = DIR_LEFT;
            end else begin
              state_nx  = SCORE;
              scorer_nx = PLAYER_1;
            end
          end
        end
      end
      SCORE: begin
        cnt_nx = '0;
        if (scorer == PLAYER_1) begin
          s1_nx  = inc_1;
          pt1_nx = 1'b1;
        end else begin
          s2_nx  = inc_2;
          pt2_nx = 1'b1;
        end
        if ((scorer == PLAYER_1 ? inc_1 : inc_2) == WIN) begin
          state_nx = OVER;
          win_nx   = scorer;
        end else begin
          // Serve toward whoever just conceded.
          state_nx = SERVE;
          dir_x_nx = (scorer == PLAYER_1) ? DIR_RIGHT : DIR_LEFT;
          bx_nx    = CX;
          by_nx    = CY;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // Ball, direction, serve counter, score and pulse registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ball_x    <= CX;
      ball_y    <= CY;
      dir_x     <= DIR_RIGHT;
      dir_y     <= DIR_DOWN;
      serve_cnt <= '0;
      score_1   <= '0;
      score_2   <= '0;
      point_1   <= 1'b0;
      point_2   <= 1'b0;
      winner    <= 1'b0;
      scorer    <= PLAYER_1;
    end else begin
      ball_x    <= bx_nx;
      ball_y    <= by_nx;
      dir_x     <= dir_x_nx;
      dir_y     <= dir_y_nx;
      serve_cnt <= cnt_nx;
      score_1   <= s1_nx;
      score_2   <= s2_nx;
      point_1   <= pt1_nx;
      point_2   <= pt2_nx;
      winner    <= win_nx;
      scorer    <= scorer_nx;
    end
  end

  assign bus.ball_x    = ball_x;
  assign bus.ball_y    = ball_y;
  assign bus.p1_y      = p1_y;
  assign bus.p2_y      = p2_y;
  assign bus.score_1   = score_1;
  assign bus.score_2   = score_2;
  assign bus.point_1   = point_1;
  assign bus.point_2   = point_2;
  assign bus.game_over = (state == OVER);
  assign bus.winner    = winner;
  assign bus.state_out = state;
endmodule

// File: tb/tb_pong_engine.sv
// Bench for pong_engine: behavioural game model feeds a per-cycle scoreboard.
// Latency: expected values are queued with each stimulus and popped after the edge.
// Backpressure: n/a.
module tb_pong_engine;
  import pong_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pong_if #(.COORD_W(10), .SCORE_W(4)) bus ();

  pong_engine dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    int st, bx, by, p1, p2, s1, s2, pt1, pt2, go, win;
    bit ball_chk;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad   = 0;

  // Reference model state
  state_t m_st;
  int m_bx, m_by, m_dx, m_dy, m_cnt, m_p1, m_p2, m_s1, m_s2, m_pt1, m_pt2, m_win, m_scorer;

  task automatic check(input string tag, input logic [31:0] got, input int want);
    total++;
    if (got !== 32'(want)) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, got, want);
    end
  endtask

  function automatic int pad(input int y, input bit u, input bit d);
    int v = y;
    if (u && !d) v -= 4;
    else if (d && !u) v += 4;
    if (v < 32) v = 32;
    else if (v > 447) v = 447;
    return v;
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  task automatic model(input bit r, t, s, u1, d1, u2, d2);
    int np1, np2, nx, ny;
    m_pt1 = 0;
    m_pt2 = 0;
    if (!r) begin
      m_st = IDLE; m_bx = 320; m_by = 240; m_p1 = 240; m_p2 = 240;
      m_s1 = 0; m_s2 = 0; m_win = 0; m_dx = 1; m_dy = 1; m_cnt = 0;
      return;
    end
    np1 = m_p1;
    np2 = m_p2;
    if (t && (m_st == SERVE || m_st == PLAY)) begin
      np1 = pad(m_p1, u1, d1);
      np2 = pad(m_p2, u2, d2);
    end
    case (m_st)
      IDLE, OVER: if (s) begin
        m_st = SERVE; m_s1 = 0; m_s2 = 0; m_win = 0; m_dx = 1; m_cnt = 0;
        m_bx = 320; m_by = 240;
      end
      SERVE: if (t) begin
        if (m_cnt == 59) begin m_st = PLAY; m_cnt = 0; m_dy = -m_dy; end
        else m_cnt++;
      end
      PLAY: if (t) begin
        nx = m_bx + 2 * m_dx;
        ny = m_by + 2 * m_dy;
        if (ny <= 4) begin ny = 4; m_dy = 1; end
        else if (ny >= 475) begin ny = 475; m_dy = -1; end
        if (m_dx < 0 && nx <= 20) begin
          if (iabs(m_by - m_p1) <= 36) begin nx = 20; m_dx = 1; end
          else begin m_st = SCORE; m_scorer = 2; end
        end else if (m_dx > 0 && nx >= 619) begin
          if (iabs(m_by - m_p2) <= 36) begin nx = 619; m_dx = -1; end
          else begin m_st = SCORE; m_scorer = 1; end
        end
        m_bx = nx;
        m_by = ny;
      end
      SCORE: begin
        m_cnt = 0;
        if (m_scorer == 1) begin
          m_s1 = (m_s1 < 15) ? m_s1 + 1 : 15;
          m_pt1 = 1;
          if (m_s1 == 7) begin m_st = OVER; m_win = 0; end
          else begin m_st = SERVE; m_dx = 1; m_bx = 320; m_by = 240; end
        end else begin
          m_s2 = (m_s2 < 15) ? m_s2 + 1 : 15;
          m_pt2 = 1;
          if (m_s2 == 7) begin m_st = OVER; m_win = 1; end
          else begin m_st = SERVE; m_dx = -1; m_bx = 320; m_by = 240; end
        end
      end
      default: m_st = IDLE;
    endcase
    m_p1 = np1;
    m_p2 = np2;
  endtask

  task automatic step(input bit r, t, s, u1, d1, u2, d2);
    exp_t e;
    rst = r; bus.tick = t; bus.start = s;
    bus.p1_up = u1; bus.p1_dn = d1; bus.p2_up = u2; bus.p2_dn = d2;
    model(r, t, s, u1, d1, u2, d2);
    e.st = int'(m_st); e.bx = m_bx; e.by = m_by; e.p1 = m_p1; e.p2 = m_p2;
    e.s1 = m_s1; e.s2 = m_s2; e.pt1 = m_pt1; e.pt2 = m_pt2;
    e.go = (m_st == OVER) ? 1 : 0; e.win = m_win;
    e.ball_chk = !(m_st == SCORE || m_st == OVER);
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check("state", bus.state_out, e.st);
    if (e.ball_chk) begin
      check("ball_x", bus.ball_x, e.bx);
      check("ball_y", bus.ball_y, e.by);
    end
    check("p1_y", bus.p1_y, e.p1);
    check("p2_y", bus.p2_y, e.p2);
    check("score_1", bus.score_1, e.s1);
    check("score_2", bus.score_2, e.s2);
    check("point_1", bus.point_1, e.pt1);
    check("point_2", bus.point_2, e.pt2);
    check("game_over", bus.game_over, e.go);
    check("winner", bus.winner, e.win);
  endtask

  initial begin
    int guard;
    bit tk, au, ad, bu, bd;
    tk = 1'b0;
    m_scorer = 1;

    // Reset, then idle holds regardless of ticks
    repeat (3) step(0, 1, 0, 0, 0, 0, 0);
    repeat (3) step(1, 1, 0, 1, 0, 0, 1);
    step(1, 0, 1, 0, 0, 0, 0);

    // Serve: p1 held up until clamped, p2 both buttons (no move)
    guard = 0;
    while (m_st == SERVE && guard < 1000) begin
      tk = ~tk; guard++;
      step(1, tk, 0, 1, 0, 1, 1);
    end
    if (guard >= 1000) check("serve_timeout", guard, 0);
    check("serve_to_play", bus.state_out, int'(PLAY));
    check("p1_clamped", bus.p1_y, 32);
    check("p2_both_held", bus.p2_y, 240);
    step(1, 1, 0, 0, 0, 0, 0);
    tk = 1'b1;
    check("first_play_x", bus.ball_x, 322);
    check("first_play_y", ((bus.ball_y == 10'd238) || (bus.ball_y == 10'd242)) ? 1 : 0, 1);

    // P1 dodges the ball, P2 tracks it: P2 takes the first point
    guard = 0;
    while (m_st != OVER && m_s2 < 1 && guard < 20000) begin
      tk = ~tk; guard++;
      au = (m_by >= m_p1); ad = (m_by < m_p1);
      bu = (m_by < m_p2 - 2); bd = (m_by > m_p2 + 2);
      step(1, tk, ($urandom_range(0, 15) == 0), au, ad, bu, bd);
    end
    if (guard >= 20000) check("phase1_timeout", guard, 0);

    // P1 tracks, P2 parks at the top: P1 plays on to the win
    guard = 0;
    while (m_st != OVER && guard < 40000) begin
      tk = ~tk; guard++;
      au = (m_by < m_p1 - 2); ad = (m_by > m_p1 + 2);
      step(1, tk, ($urandom_range(0, 15) == 0), au, ad, 1, 0);
    end
    if (guard >= 40000) check("phase2_timeout", guard, 0);
    check("over_flag", bus.game_over, 1);
    check("over_winner", bus.winner, (m_s1 == 7) ? 0 : 1);
    check("over_score_1", bus.score_1, m_s1);

    // Frozen in OVER, then restart
    repeat (6) step(1, 1, 0, 1, 0, 0, 1);
    step(1, 0, 1, 0, 0, 0, 0);
    check("restart_state", bus.state_out, int'(SERVE));
    check("restart_score_1", bus.score_1, 0);

    guard = 0;
    while (m_st == SERVE && guard < 1000) begin
      tk = ~tk; guard++;
      step(1, tk, 0, 0, 1, 1, 0);
    end
    if (guard >= 1000) check("restart_timeout", guard, 0);
    repeat (20) begin
      tk = ~tk;
      step(1, tk, 0, 0, 1, 1, 0);
    end

    // Reset during a tick in PLAY
    step(0, 1, 0, 1, 0, 0, 1);
    check("rst_state", bus.state_out, int'(IDLE));
    check("rst_ball_x", bus.ball_x, 320);
    check("rst_p1_y", bus.p1_y, 240);
    repeat (4) step(1, 1, 0, 1, 0, 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
